output_drain_dma: RTL and testbench
===================================

# output_drain_dma

Drain engine for the output path: the reading end of the output accumulator's DMA read port. On `start` it waits for the accumulator's inactive bank to report ready, issues sequential 64-bit reads (8 INT8 results per word), and absorbs the fixed 2-cycle read latency in a small credit-managed FIFO. It presents the words as an addressed valid/ready beat stream to the AXI write master, then pulses `done`.

## Interface
Parameters:
- `NUM_ELEMS`, 196, number of INT8 results per tile (N_ROWS*N_COLS).
- `NUM_WORDS`, 25, 64-bit words per tile, equal to ceil(NUM_ELEMS/8).
- `ADDR_W`, 10, width of the accumulator read address.
- `FIFO_DEPTH`, 4, number of output FIFO entries; power of 2, at least 4.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a drain. Sampled only in IDLE.
- `dst_base` in 32: destination byte address, 8-byte aligned. Latched on an accepted `start`.
- `acc_dma_ready` in 1: accumulator reports that its inactive bank holds a finished tile.
- `acc_rd_en` out 1: registered read strobe to the accumulator.
- `acc_rd_addr` out ADDR_W: registered word address.
- `acc_rd_data` in 64: quantized data, valid 2 cycles after `acc_rd_en`.
- `m_valid` out 1: output beat valid.
- `m_ready` in 1: downstream accepts the beat.
- `m_data` out 64: output beat payload.
- `m_addr` out 32: destination byte address of the beat.
- `m_strb` out 8: byte enables of the beat.
- `m_last` out 1: marks the final beat of the tile.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the drain completes.
- `stall_cycles` out 32: backpressure counter (see Configuration).

## Operation
State machine: IDLE → WAIT_RDY → READ → FLUSH → DONE → IDLE.
- **IDLE:** on `start`, latch `dst_base` and clear the issue and beat indices, then go to WAIT_RDY. Any `start` outside IDLE is ignored.
- **WAIT_RDY:** when `acc_dma_ready`=1, go to READ. `acc_dma_ready` is checked only here, because the accumulator clears it on the first read strobe.
- **READ:** issue one read per cycle while `fifo_count + inflight < FIFO_DEPTH`. Addresses are 0..NUM_WORDS-1 in order. After issuing address NUM_WORDS-1, go to FLUSH.
- **FLUSH:** wait until in-flight reads are 0, the FIFO is empty, and the last beat has been accepted; then go to DONE.
- **DONE:** assert `done` for one cycle and return to IDLE.

Datapath rules:
- `inflight` is a 2-stage valid shift register fed by `acc_rd_en`. Its output pushes `acc_rd_data` into the FIFO. The credit check guarantees the push can never overflow the FIFO.
- Beat k carries `m_addr` = latched `dst_base` + 8·k (32-bit wrap, no error).
- `m_strb`:
  - 0xFF on every beat except the last.
  - On the last beat, the low (NUM_ELEMS mod 8) bits are set, or 0xFF when that remainder is 0.
  - With defaults, the last beat (k=24) carries 0x0F.
- `m_last`=1 only on beat NUM_WORDS-1.
- Output handshake:
  - A beat transfers when `m_valid` && `m_ready`.
  - `m_valid`, `m_data`, `m_addr`, `m_strb` and `m_last` hold stable while `m_valid` && !`m_ready`.
  - `m_valid` is never withdrawn before the beat is accepted.
- FIFO push and pop in the same cycle are both allowed and leave the count unchanged.

## Timing
- **Reset:** `rst`=1 at an edge sets the FSM to IDLE and forces every output to 0 (`acc_rd_en`, `acc_rd_addr`, `m_*`, `busy`, `done`, `stall_cycles`). FIFO, indices and the in-flight pipe are cleared. A reset during a drain abandons it; data still returning from the accumulator is dropped.
- **Read latency:** if `acc_rd_en`=1 in cycle t, `acc_rd_data` is captured at the end of cycle t+2. The earliest `m_valid` is cycle t+3.
- **Start-up:** with `acc_dma_ready` already high, `start` in cycle 0 gives WAIT_RDY in cycle 1 and the first `acc_rd_en` in cycle 2.
- **Throughput:** with `m_ready` held at 1, one read is issued per cycle. A drain takes NUM_WORDS + 5 cycles from `start` to `done`.
- **Credit stall:** with `m_ready`=0, at most FIFO_DEPTH reads are issued; `acc_rd_en` then stays low until a pop.
- **`busy`:** rises the cycle after an accepted `start` and falls in the same cycle `done` deasserts (back in IDLE).

## Configuration
- **`DRAIN_PERF_CNT_EN` defined:** `stall_cycles` increments every cycle where `m_valid`=1 and `m_ready`=0. It clears on an accepted `start` and saturates at 0xFFFFFFFF.
- **Not defined:** `stall_cycles` is tied to 0 and no counter logic is built.

## Test plan
- **Basic drain:** `dst_base`=0x1000, `acc_dma_ready`=1, `m_ready`=1, `start`. Expect `acc_rd_addr` 0..24 on consecutive cycles, 25 beats with `m_addr` 0x1000..0x10C0, `m_strb`=0x0F and `m_last`=1 on beat 24, and `done` exactly 30 cycles after `start`.
- **Late ready:** `acc_dma_ready` rises 10 cycles after `start`. Expect no `acc_rd_en` before then, and the first read on the cycle after it rises.
- **Backpressure:** `m_ready`=0 for 20 cycles. Expect exactly 4 reads issued, beat 0 held stable, and `stall_cycles`=20 with the macro defined (0 without). After release, all 25 beats arrive in order with no loss or duplication.
- **Random `m_ready`:** 50% random `m_ready`, with the accumulator model returning word k = {8{k[7:0]}}. Expect the beat sequence to match that pattern and the FIFO never to overflow.
- **Start while busy:** pulse `start` again in READ. Expect it ignored: one `done`, 25 beats total.
- **Reset mid-drain:** assert `rst` after beat 10. Expect all outputs 0 on the next cycle and no beats afterwards. A fresh `start` then drains all 25 beats from address 0.

Source files
------------

// File: rtl/output_drain_dma.sv
// Output drain engine: reads a finished tile from the accumulator and streams it as addressed 64-bit beats.
// Optional feature macro: DRAIN_PERF_CNT_EN (builds the backpressure stall counter behind o_stall_cycles).
module output_drain_dma #(
    parameter int NUM_ELEMS  = 196,
    parameter int NUM_WORDS  = 25,
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [31:0]       i_dst_base,
    input  logic              i_acc_dma_ready,
    output logic              o_acc_rd_en,
    output logic [ADDR_W-1:0] o_acc_rd_addr,
    input  logic [63:0]       i_acc_rd_data,
    output logic              o_m_valid,
    input  logic              i_m_ready,
    output logic [63:0]       o_m_data,
    output logic [31:0]       o_m_addr,
    output logic [7:0]        o_m_strb,
    output logic              o_m_last,
    output logic              o_busy,
    output logic              o_done,
    output logic [31:0]       o_stall_cycles,
    output logic [2:0]        o_dbg_state
);

    // Output handshake: a beat moves when o_m_valid && i_m_ready; while o_m_valid is high and
    // i_m_ready is low, o_m_valid/data/addr/strb/last hold, and o_m_valid never drops unaccepted.

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_READ     = 3'd2,
        S_FLUSH    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 2;
    localparam int IDX_W    = $clog2(NUM_WORDS + 1);
    localparam int LAST_REM = NUM_ELEMS % 8;
    localparam logic [7:0] LAST_STRB = (LAST_REM == 0) ? 8'hFF : 8'((1 << LAST_REM) - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [31:0]        r_base;
    logic [IDX_W-1:0]   r_issue_idx;
    logic [IDX_W-1:0]   r_beat_idx;
    logic               r_acc_rd_en;
    logic [ADDR_W-1:0]  r_acc_rd_addr;
    logic [1:0]         r_pipe;
    logic [63:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_start;
    logic               w_push;
    logic               w_pop;
    logic [CNT_W-1:0]   w_outstanding;
    logic               w_credit;
    logic               w_issue;
    logic               w_issue_last;
    logic               w_last_beat;
    logic               w_drained;

    assign w_start = (r_state == S_IDLE) && i_start;
    assign w_push  = r_pipe[1];
    assign w_pop   = o_m_valid && i_m_ready;

    // Every read not yet popped holds a FIFO slot; a pop this cycle frees one immediately.
    assign w_outstanding = r_count + CNT_W'(r_acc_rd_en) + CNT_W'(r_pipe[0])
                         + CNT_W'(r_pipe[1]) - CNT_W'(w_pop);
    assign w_credit      = w_outstanding < CNT_W'(FIFO_DEPTH);

    assign w_issue      = ((r_state == S_READ) || ((r_state == S_WAIT_RDY) && i_acc_dma_ready))
                        && w_credit && (r_issue_idx < IDX_W'(NUM_WORDS));
    assign w_issue_last = w_issue && (r_issue_idx == IDX_W'(NUM_WORDS - 1));
    assign w_last_beat  = (r_beat_idx == IDX_W'(NUM_WORDS - 1));
    assign w_drained    = w_pop && w_last_beat && (r_pipe == 2'b00) && (r_count == CNT_W'(1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:     if (i_start) w_next_state = S_WAIT_RDY;
            S_WAIT_RDY: if (i_acc_dma_ready) w_next_state = w_issue_last ? S_FLUSH : S_READ;
            S_READ:     if (w_issue_last) w_next_state = S_FLUSH;
            S_FLUSH:    if (w_drained) w_next_state = S_DONE;
            S_DONE:     w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy      = (r_state != S_IDLE);
        o_done      = (r_state == S_DONE);
        o_dbg_state = r_state;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_base        <= '0;
            r_issue_idx   <= '0;
            r_beat_idx    <= '0;
            r_acc_rd_en   <= 1'b0;
            r_acc_rd_addr <= '0;
            r_pipe        <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
        end else begin
            if (w_start) begin
                r_base      <= i_dst_base;
                r_issue_idx <= '0;
                r_beat_idx  <= '0;
            end
            r_acc_rd_en <= w_issue;
            if (w_issue) begin
                r_acc_rd_addr <= ADDR_W'(r_issue_idx);
                r_issue_idx   <= r_issue_idx + 1'b1;
            end
            r_pipe <= {r_pipe[0], r_acc_rd_en};
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_beat_idx <= r_beat_idx + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is only visible while r_count is non-zero.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_acc_rd_data;
        end
    end

    assign o_acc_rd_en   = r_acc_rd_en;
    assign o_acc_rd_addr = r_acc_rd_addr;

    always_comb begin
        o_m_valid = (r_count != '0);
        o_m_data  = '0;
        o_m_addr  = '0;
        o_m_strb  = '0;
        o_m_last  = 1'b0;
        if (o_m_valid) begin
            o_m_data = r_mem[r_rd_ptr];
            o_m_addr = r_base + (32'(r_beat_idx) << 3);
            o_m_strb = w_last_beat ? LAST_STRB : 8'hFF;
            o_m_last = w_last_beat;
        end
    end

`ifdef DRAIN_PERF_CNT_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cycles <= '0;
        end else if (w_start) begin
            r_stall_cycles <= '0;
        end else if (o_m_valid && !i_m_ready && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
`else
    assign o_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_output_drain_dma.sv
// Directed bench for output_drain_dma: basic drain, late ready, backpressure, random ready, restart, mid-drain reset.
module tb_output_drain_dma;

  localparam int NW = 25;
`ifdef DRAIN_PERF_CNT_EN
  localparam int EXP_STALL = 20;
`else
  localparam int EXP_STALL = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dst_base;
  logic        acc_dma_ready;
  logic        acc_rd_en;
  logic [9:0]  acc_rd_addr;
  logic [63:0] acc_rd_data;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_data;
  logic [31:0] m_addr;
  logic [7:0]  m_strb;
  logic        m_last;
  logic        busy;
  logic        done;
  logic [31:0] stall_cycles;
  logic [2:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  output_drain_dma dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_dst_base(dst_base),
    .i_acc_dma_ready(acc_dma_ready), .o_acc_rd_en(acc_rd_en), .o_acc_rd_addr(acc_rd_addr),
    .i_acc_rd_data(acc_rd_data), .o_m_valid(m_valid), .i_m_ready(m_ready), .o_m_data(m_data),
    .o_m_addr(m_addr), .o_m_strb(m_strb), .o_m_last(m_last), .o_busy(busy), .o_done(done),
    .o_stall_cycles(stall_cycles), .o_dbg_state(dbg_state)
  );

  // clock / reset / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  // accumulator model: word k = {8{k[7:0]}}, two-cycle read latency
  logic [63:0] acc_d1, acc_d2;
  always @(posedge clk) begin
    acc_d1 <= {8{acc_rd_addr[7:0]}};
    acc_d2 <= acc_d1;
  end
  assign acc_rd_data = acc_d2;

  // monitor: logs reads, accepted beats, done pulses and hold violations
  logic [9:0]  rd_addr_q[$];
  int          rd_cyc_q[$];
  logic [63:0] b_data_q[$];
  logic [31:0] b_addr_q[$];
  logic [7:0]  b_strb_q[$];
  logic        b_last_q[$];
  int          b_cyc_q[$];
  int          done_cyc_q[$];
  int          hold_err = 0;
  logic        p_hold = 1'b0;
  logic [63:0] p_data;
  logic [31:0] p_addr;
  logic [7:0]  p_strb;
  logic        p_last;

  always @(negedge clk) begin
    if (!rst) begin
      if (acc_rd_en) begin
        rd_addr_q.push_back(acc_rd_addr);
        rd_cyc_q.push_back(cyc);
      end
      if (m_valid && m_ready) begin
        b_data_q.push_back(m_data);
        b_addr_q.push_back(m_addr);
        b_strb_q.push_back(m_strb);
        b_last_q.push_back(m_last);
        b_cyc_q.push_back(cyc);
      end
      if (done) done_cyc_q.push_back(cyc);
      if (p_hold && (m_valid !== 1'b1 || m_data !== p_data || m_addr !== p_addr ||
                     m_strb !== p_strb || m_last !== p_last)) hold_err++;
    end
    p_hold = !rst && m_valid && !m_ready;
    p_data = m_data;
    p_addr = m_addr;
    p_strb = m_strb;
    p_last = m_last;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_drain(input logic [31:0] base, output int t0);
    t0 = cyc;
    dst_base = base;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int d0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_cyc_q.size() > d0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({acc_rd_en, acc_rd_addr} !== 11'd0) begin
      errors++; $display("FAIL reset_rd: got %h expected 0", {acc_rd_en, acc_rd_addr});
    end
    checks++;
    if ({m_valid, m_data, m_addr, m_strb, m_last} !== 106'd0) begin
      errors++; $display("FAIL reset_m: got %h expected 0", {m_valid, m_data, m_addr, m_strb, m_last});
    end
    checks++;
    if ({busy, done, stall_cycles} !== 34'd0) begin
      errors++; $display("FAIL reset_status: got %h expected 0", {busy, done, stall_cycles});
    end
    checks++;
    if (dbg_state !== 3'd0) begin
      errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int t0, r0, b0, d0, h0;
    bit ok;
    logic [7:0] kb;
    acc_dma_ready = 1'b1;
    m_ready = 1'b1;
    r0 = rd_addr_q.size(); b0 = b_data_q.size(); d0 = done_cyc_q.size(); h0 = hold_err;
    start_drain(32'h0000_1000, t0);
    wait_done(100, d0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_done_seen: got none expected done"); end
    checks++;
    if (rd_addr_q.size() - r0 != NW) begin
      errors++; $display("FAIL basic_rd_count: got %0d expected %0d", rd_addr_q.size() - r0, NW);
    end
    for (int k = 0; k < NW && r0 + k < rd_addr_q.size(); k++) begin
      checks++;
      if (rd_addr_q[r0+k] !== 10'(k) || rd_cyc_q[r0+k] != t0 + 2 + k) begin
        errors++;
        $display("FAIL basic_rd[%0d]: got addr %0d cyc %0d expected addr %0d cyc %0d",
                 k, rd_addr_q[r0+k], rd_cyc_q[r0+k] - t0, k, 2 + k);
      end
    end
    checks++;
    if (b_data_q.size() - b0 != NW) begin
      errors++; $display("FAIL basic_beat_count: got %0d expected %0d", b_data_q.size() - b0, NW);
    end
    for (int k = 0; k < NW && b0 + k < b_data_q.size(); k++) begin
      kb = k[7:0];
      checks++;
      if (b_data_q[b0+k] !== {8{kb}} || b_addr_q[b0+k] !== 32'h1000 + 32'(8 * k) ||
          b_strb_q[b0+k] !== ((k == NW - 1) ? 8'h0F : 8'hFF) || b_last_q[b0+k] !== (k == NW - 1) ||
          b_cyc_q[b0+k] != t0 + 5 + k) begin
        errors++;
        $display("FAIL basic_beat[%0d]: got data %h addr %h strb %h last %0d cyc %0d expected data %h addr %h cyc %0d",
                 k, b_data_q[b0+k], b_addr_q[b0+k], b_strb_q[b0+k], b_last_q[b0+k], b_cyc_q[b0+k] - t0,
                 {8{kb}}, 32'h1000 + 32'(8 * k), 5 + k);
      end
    end
    checks++;
    if (done_cyc_q.size() <= d0 || done_cyc_q[d0] != t0 + 30) begin
      errors++; $display("FAIL basic_done_cycle: got %0d expected 30",
                         (done_cyc_q.size() > d0) ? done_cyc_q[d0] - t0 : -1);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL basic_after_done: got busy %0d done %0d expected 0 0", busy, done);
    end
    checks++;
    if (hold_err != h0 || stall_cycles !== 32'd0) begin
      errors++; $display("FAIL basic_hold_stall: got hold %0d stall %0d expected 0 0", hold_err - h0, stall_cycles);
    end
    tick();
  endtask

  task automatic test_late_ready();
    int t0, r0, b0, d0;
    bit ok;
    acc_dma_ready = 1'b0;
    m_ready = 1'b1;
    r0 = rd_addr_q.size(); b0 = b_data_q.size(); d0 = done_cyc_q.size();
    start_drain(32'h0000_0800, t0);
    while (cyc < t0 + 10) tick();
    checks++;
    if (rd_addr_q.size() != r0 || busy !== 1'b1) begin
      errors++; $display("FAIL late_no_early_read: got reads %0d busy %0d expected 0 1", rd_addr_q.size() - r0, busy);
    end
    acc_dma_ready = 1'b1;
    wait_done(100, d0, ok);
    checks++;
    if (rd_cyc_q.size() <= r0 || rd_cyc_q[r0] != t0 + 11) begin
      errors++; $display("FAIL late_first_read: got %0d expected 11", (rd_cyc_q.size() > r0) ? rd_cyc_q[r0] - t0 : -1);
    end
    checks++;
    if (!ok || done_cyc_q[d0] != t0 + 39 || b_data_q.size() - b0 != NW) begin
      errors++; $display("FAIL late_done: got ok %0d beats %0d expected done at 39 and %0d beats",
                         ok, b_data_q.size() - b0, NW);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int t0, r0, b0, d0, h0;
    bit ok;
    logic [7:0] kb;
    acc_dma_ready = 1'b1;
    m_ready = 1'b0;
    r0 = rd_addr_q.size(); b0 = b_data_q.size(); d0 = done_cyc_q.size(); h0 = hold_err;
    start_drain(32'h0000_8000, t0);
    while (cyc < t0 + 24) tick();
    @(negedge clk);
    checks++;
    if (rd_addr_q.size() - r0 != 4) begin
      errors++; $display("FAIL bp_reads: got %0d expected 4", rd_addr_q.size() - r0);
    end
    checks++;
    if (m_valid !== 1'b1 || m_addr !== 32'h0000_8000 || m_data !== 64'd0 || m_strb !== 8'hFF) begin
      errors++; $display("FAIL bp_beat0_held: got valid %0d addr %h data %h strb %h expected 1 00008000 0 ff",
                         m_valid, m_addr, m_data, m_strb);
    end
    tick();
    m_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (stall_cycles !== 32'(EXP_STALL)) begin
      errors++; $display("FAIL bp_stall: got %0d expected %0d", stall_cycles, EXP_STALL);
    end
    wait_done(200, d0, ok);
    checks++;
    if (!ok || done_cyc_q[d0] != t0 + 50 || rd_addr_q.size() - r0 != NW) begin
      errors++; $display("FAIL bp_done: got ok %0d reads %0d expected done at 50 and %0d reads",
                         ok, rd_addr_q.size() - r0, NW);
    end
    checks++;
    if (b_data_q.size() - b0 != NW || hold_err != h0) begin
      errors++; $display("FAIL bp_beats: got %0d beats hold %0d expected %0d beats hold 0",
                         b_data_q.size() - b0, hold_err - h0, NW);
    end
    for (int k = 0; k < NW && b0 + k < b_data_q.size(); k++) begin
      kb = k[7:0];
      checks++;
      if (b_data_q[b0+k] !== {8{kb}} || b_addr_q[b0+k] !== 32'h8000 + 32'(8 * k)) begin
        errors++; $display("FAIL bp_beat[%0d]: got data %h addr %h expected data %h addr %h",
                           k, b_data_q[b0+k], b_addr_q[b0+k], {8{kb}}, 32'h8000 + 32'(8 * k));
      end
    end
    checks++;
    if (stall_cycles !== 32'(EXP_STALL)) begin
      errors++; $display("FAIL bp_stall_final: got %0d expected %0d", stall_cycles, EXP_STALL);
    end
    tick();
  endtask

  task automatic test_random();
    int t0, b0, d0, h0, n;
    logic [63:0] exp_q[$];
    logic [7:0] kb;
    bit ok;
    for (int k = 0; k < NW; k++) begin
      kb = k[7:0];
      exp_q.push_back({8{kb}});
    end
    b0 = b_data_q.size(); d0 = done_cyc_q.size(); h0 = hold_err;
    start_drain(32'hFFFF_FF80, t0);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (done_cyc_q.size() > d0) begin ok = 1'b1; break; end
      m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    m_ready = 1'b1;
    checks++;
    if (!ok || b_data_q.size() - b0 != NW) begin
      errors++; $display("FAIL rand_done: got ok %0d beats %0d expected 1 %0d", ok, b_data_q.size() - b0, NW);
    end
    n = 0;
    while (exp_q.size() > 0 && b0 + n < b_data_q.size()) begin
      checks++;
      if (b_data_q[b0+n] !== exp_q[0] || b_addr_q[b0+n] !== 32'hFFFF_FF80 + 32'(8 * n)) begin
        errors++; $display("FAIL rand_beat[%0d]: got data %h addr %h expected data %h addr %h",
                           n, b_data_q[b0+n], b_addr_q[b0+n], exp_q[0], 32'hFFFF_FF80 + 32'(8 * n));
      end
      void'(exp_q.pop_front());
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || hold_err != h0) begin
      errors++; $display("FAIL rand_leftover: got missing %0d hold %0d expected 0 0", exp_q.size(), hold_err - h0);
    end
    tick();
  endtask

  task automatic test_start_while_busy();
    int t0, r0, b0, d0;
    bit ok;
    m_ready = 1'b1;
    r0 = rd_addr_q.size(); b0 = b_data_q.size(); d0 = done_cyc_q.size();
    start_drain(32'h0000_4000, t0);
    while (cyc < t0 + 5) tick();
    dst_base = 32'hDEAD_0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(100, d0, ok);
    repeat (10) tick();
    checks++;
    if (done_cyc_q.size() - d0 != 1 || b_data_q.size() - b0 != NW || rd_addr_q.size() - r0 != NW) begin
      errors++; $display("FAIL busy_start_counts: got done %0d beats %0d reads %0d expected 1 %0d %0d",
                         done_cyc_q.size() - d0, b_data_q.size() - b0, rd_addr_q.size() - r0, NW, NW);
    end
    checks++;
    if (b_addr_q.size() < b0 + NW || b_addr_q[b0] !== 32'h4000 || b_addr_q[b0+NW-1] !== 32'h40C0 || busy !== 1'b0) begin
      errors++; $display("FAIL busy_start_addr: got first %h last %h busy %0d expected 00004000 000040c0 0",
                         b_addr_q[b0], b_addr_q[b0+NW-1], busy);
    end
  endtask

  task automatic test_reset_mid();
    int t0, r1, b0, b1, d0;
    bit ok;
    logic [7:0] kb;
    m_ready = 1'b1;
    b0 = b_data_q.size(); d0 = done_cyc_q.size();
    start_drain(32'h0000_2000, t0);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (b_data_q.size() - b0 >= 11) begin ok = 1'b1; break; end
      tick();
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_progress: got %0d beats expected 11", b_data_q.size() - b0); end
    rst = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if ({acc_rd_en, acc_rd_addr, m_valid, m_data, m_addr, m_strb, m_last, busy, done, stall_cycles} !== 151'd0) begin
      errors++; $display("FAIL rstmid_outputs: got %h expected 0",
                         {acc_rd_en, acc_rd_addr, m_valid, m_data, m_addr, m_strb, m_last, busy, done, stall_cycles});
    end
    r1 = rd_addr_q.size(); b1 = b_data_q.size();
    tick();
    rst = 1'b0;
    repeat (10) tick();
    checks++;
    if (b_data_q.size() != b1 || rd_addr_q.size() != r1 || done_cyc_q.size() != d0) begin
      errors++; $display("FAIL rstmid_quiet: got beats %0d reads %0d dones %0d expected 0 0 0",
                         b_data_q.size() - b1, rd_addr_q.size() - r1, done_cyc_q.size() - d0);
    end
    start_drain(32'h0000_0000, t0);
    wait_done(100, d0, ok);
    checks++;
    if (!ok || done_cyc_q[d0] != t0 + 30 || b_data_q.size() - b1 != NW) begin
      errors++; $display("FAIL rstmid_redrain: got ok %0d beats %0d expected done at 30 and %0d beats",
                         ok, b_data_q.size() - b1, NW);
    end
    for (int k = 0; k < NW && b1 + k < b_data_q.size(); k++) begin
      kb = k[7:0];
      checks++;
      if (b_data_q[b1+k] !== {8{kb}} || b_addr_q[b1+k] !== 32'(8 * k) || b_last_q[b1+k] !== (k == NW - 1)) begin
        errors++; $display("FAIL rstmid_beat[%0d]: got data %h addr %h last %0d expected data %h addr %h last %0d",
                           k, b_data_q[b1+k], b_addr_q[b1+k], b_last_q[b1+k], {8{kb}}, 32'(8 * k), k == NW - 1);
      end
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    dst_base = '0;
    acc_dma_ready = 1'b0;
    m_ready = 1'b1;
    test_reset();
    test_basic();
    test_late_ready();
    test_backpressure();
    test_random();
    test_start_while_busy();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
